// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with 16x oversampling, small receive FIFO and a CPU-readable
// RXDATA/STATUS register pair on a one-cycle request/response bus.
module uart_rx_port #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  input  logic                  req_valid,
  input  logic                  we,
  input  logic [1:0]            addr,
  output logic                  valid_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rx_irq
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW:0]      CNT1     = (AW+1)'(1);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_r, state_nx_s;
  logic             sync_meta_r, sync_r, rx_s;
  logic [CNT_W-1:0] tick_cnt_r;
  logic             tick_s;
  logic [SC_W-1:0]  sc_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             idle_s, sc_clr_s, sc_inc_s, shift_en_s, frame_done_s;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r, count_nx_s;
  logic             full_s, empty_s, push_req_s, push_s, pop_s, ovr_set_s, ferr_set_s;
  logic             rd_data_s, rd_stat_s, ovr_r, ferr_r, valid_r, irq_r;
  logic [DATA_WIDTH-1:0] rdata_nx_s, rdata_r;

  assign rx_s   = sync_r;
  assign tick_s = (tick_cnt_r == DIV_LAST);

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_r <= 1'b1;
      sync_r      <= 1'b1;
    end else begin
      sync_meta_r <= rxd;
      sync_r      <= sync_meta_r;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Receiver next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (!rx_s) state_nx_s = ST_START; else state_nx_s = ST_IDLE;
      ST_START: if (tick_s && sc_r == SC_HALF) state_nx_s = rx_s ? ST_IDLE : ST_DATA;
                else state_nx_s = ST_START;
      ST_DATA:  if (tick_s && sc_r == SC_LAST && bit_idx_r == 3'd7) state_nx_s = ST_STOP;
                else state_nx_s = ST_DATA;
      ST_STOP:  if (tick_s && sc_r == SC_LAST) state_nx_s = ST_IDLE;
                else state_nx_s = ST_STOP;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Receiver control strobes; the stop-bit sample and return to idle share one cycle
  always_comb begin
    idle_s       = 1'b0;
    sc_clr_s     = 1'b0;
    sc_inc_s     = 1'b0;
    shift_en_s   = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      ST_IDLE: idle_s = 1'b1;
      ST_START: begin
        if (tick_s) begin
          if (sc_r == SC_HALF) sc_clr_s = 1'b1;
          else                 sc_inc_s = 1'b1;
        end else begin
          sc_inc_s = 1'b0;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (sc_r == SC_LAST) begin
            sc_clr_s   = 1'b1;
            shift_en_s = 1'b1;
          end else begin
            sc_inc_s = 1'b1;
          end
        end else begin
          sc_inc_s = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (sc_r == SC_LAST) begin
            sc_clr_s     = 1'b1;
            frame_done_s = 1'b1;
          end else begin
            sc_inc_s = 1'b1;
          end
        end else begin
          sc_inc_s = 1'b0;
        end
      end
      default: idle_s = 1'b1;
    endcase
  end

  // Tick divider, sample counter, bit index and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= {CNT_W{1'b0}};
      sc_r       <= {SC_W{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
    end else begin
      if (idle_s || tick_s) tick_cnt_r <= {CNT_W{1'b0}};
      else                  tick_cnt_r <= tick_cnt_r + CNT_ONE;
      if (idle_s || sc_clr_s) sc_r <= {SC_W{1'b0}};
      else if (sc_inc_s)      sc_r <= sc_r + SC_ONE;
      else                    sc_r <= sc_r;
      if (idle_s)          bit_idx_r <= 3'd0;
      else if (shift_en_s) bit_idx_r <= bit_idx_r + 3'd1;
      else                 bit_idx_r <= bit_idx_r;
      if (shift_en_s) shift_r <= {rx_s, shift_r[7:1]};
      else            shift_r <= shift_r;
    end
  end

  assign full_s     = (count_r == FULL_CNT);
  assign empty_s    = (count_r == {(AW+1){1'b0}});
  assign rd_data_s  = req_valid && !we && (addr == 2'd0);
  assign rd_stat_s  = req_valid && !we && (addr == 2'd1);
  assign pop_s      = rd_data_s && !empty_s;
  assign push_req_s = frame_done_s && rx_s;
  assign ferr_set_s = frame_done_s && !rx_s;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign push_s     = push_req_s && (!full_s || pop_s);
  assign ovr_set_s  = push_req_s && full_s && !pop_s;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT1;
      2'b01:   count_nx_s = count_r - CNT1;
      default: count_nx_s = count_r;
    endcase
  end

  // FIFO storage, pointers, sticky error flags and the interrupt level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'd0;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ovr_r    <= 1'b0;
      ferr_r   <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      else       rd_ptr_r <= rd_ptr_r;
      count_r <= count_nx_s;
      ovr_r   <= ovr_set_s  | (ovr_r  & ~rd_stat_s);
      ferr_r  <= ferr_set_s | (ferr_r & ~rd_stat_s);
      irq_r   <= (count_nx_s != {(AW+1){1'b0}});
    end
  end

  // Read-data mux; writes and unmapped addresses return zero
  always_comb begin
    rdata_nx_s = {DATA_WIDTH{1'b0}};
    if (req_valid && !we) begin
      case (addr)
        2'd0: if (!empty_s) rdata_nx_s = {{(DATA_WIDTH-8){1'b0}}, mem_r[rd_ptr_r]};
              else          rdata_nx_s = {DATA_WIDTH{1'b0}};
        2'd1: rdata_nx_s = {{(DATA_WIDTH-4){1'b0}}, ovr_r, ferr_r, full_s, ~empty_s};
        default: rdata_nx_s = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rdata_nx_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Bus response register: one strobe per request, data zero otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_r <= req_valid;
      rdata_r <= rdata_nx_s;
    end
  end

  assign valid_data = valid_r;
  assign rdata      = rdata_r;
  assign rx_irq     = irq_r;

endmodule
